// File: rtl/frame_scanout.sv
// frame_scanout: display-side reader for the frame buffer memory.
//
// Generates raster timing from free-running h/v counters, issues one
// memory read per active pixel in raster order while scanning a stored
// frame, and presents pixel_out with de/hsync/vsync aligned to the
// returned read data. A frame is scanned only when frame_rdy is high at
// the frame's first cycle. Otherwise the frame is emitted blank with full
// sync timing, and underrun pulses.
//
// Ports:
//   clk         single clock for all logic
//   reset       asynchronous, active-high reset
//   frame_rdy   write side holds high while a complete frame is stored
//   rd_data     memory read data, valid the cycle after rd_en is asserted
//   rd_en       memory read enable, active-low
//   rd_addr     memory read address (linear pixel index)
//   pixel_out   pixel data; zero outside scanned active pixels
//   de          data enable, high during active pixels
//   hsync       horizontal sync, active-high
//   vsync       vertical sync, active-high
//   frame_done  one-cycle pulse after the last pixel read of a frame
//   underrun    one-cycle pulse when a frame starts with frame_rdy low
module frame_scanout #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 3,
  parameter int H_ACTIVE   = 4,
  parameter int H_FP       = 1,
  parameter int H_SYNC     = 1,
  parameter int H_BP       = 1,
  parameter int V_ACTIVE   = 2,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 1,
  parameter int V_BP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_rdy,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic RD_ASSERT   = 1'b0;
  localparam logic RD_DEASSERT = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          at_origin;
  logic          frame_end;
  logic          active;
  logic          last_px;
  logic          hs_raw;
  logic          vs_raw;
  logic          scan_rd;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] pix_idx;
  logic                  de_p1;
  logic                  hs_p1;
  logic                  vs_p1;
  logic                  scan_p1;
  logic                  scan_p2;

  // ---- stage p0: raster counters and decode ----
  assign h_last    = (int'(h_cnt) == H_TOTAL - 1);
  assign v_last    = (int'(v_cnt) == V_TOTAL - 1);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end = h_last && v_last;
  assign active    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign last_px   = (int'(h_cnt) == H_ACTIVE - 1) && (int'(v_cnt) == V_ACTIVE - 1);
  assign hs_raw    = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                     (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw    = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                     (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // The frame decision is taken combinationally on the (0,0) cycle so the
  // first pixel's read already reflects it; reset lands on (0,0), so the
  // first frame after reset is decided the same way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (at_origin) begin
      state_d = frame_rdy ? SCAN : IDLE;
    end
  end

  assign scan_rd = active && (state_d == SCAN);

  // ---- stage p1: read request, frame events, delayed timing ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en      <= RD_DEASSERT;
      rd_addr    <= '0;
      pix_idx    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      de_p1      <= 1'b0;
      hs_p1      <= 1'b0;
      vs_p1      <= 1'b0;
      scan_p1    <= 1'b0;
    end else begin
      rd_en      <= scan_rd ? RD_ASSERT : RD_DEASSERT;
      frame_done <= scan_rd && last_px;
      underrun   <= at_origin && !frame_rdy;
      de_p1      <= active;
      hs_p1      <= hs_raw;
      vs_p1      <= vs_raw;
      scan_p1    <= (state_d == SCAN);
      // pix_idx is the next linear index to issue; the address holds
      // through blanking and restarts when the counters wrap.
      if (frame_end) begin
        rd_addr <= '0;
        pix_idx <= '0;
      end else if (scan_rd) begin
        rd_addr <= pix_idx;
        pix_idx <= pix_idx + ADDR_WIDTH'(1);
      end
    end
  end

  // ---- stage p2: timing outputs aligned with returned read data ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de      <= 1'b0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      scan_p2 <= 1'b0;
    end else begin
      de      <= de_p1;
      hsync   <= hs_p1;
      vsync   <= vs_p1;
      scan_p2 <= scan_p1;
    end
  end

  // Read data is valid in the same cycle that de lands, so it is gated
  // by the already-registered de/state rather than registered again;
  // reset clears de, so pixel_out drops to zero immediately.
  assign pixel_out = (de && scan_p2) ? rd_data : '0;

endmodule
